// File: rtl/error_unit_pkg.sv
// Shared types, constants and the shift/saturate helper for the error unit.
package error_unit_pkg;

    typedef logic [7:0]         act_t;
    typedef logic signed [15:0] err_t;
    typedef logic signed [8:0]  diff_t;

    localparam err_t ERR_MAX = 16'sh7FFF;
    localparam err_t ERR_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_SEND
    } state_t;

    // Shift the 9-bit difference left by sh (0..8) and clamp to the 16-bit range.
    // 25 bits hold 255 << 8 without overflow, so the clamp sees the true value.
    function automatic err_t sat16(input diff_t d, input int sh);
        logic signed [24:0] w;
        w = {{16{d[8]}}, d};
        w = w <<< sh;
        if (w > 25'sd32767)
            return ERR_MAX;
        else if (w < -25'sd32768)
            return ERR_MIN;
        else
            return err_t'(w[15:0]);
    endfunction

endpackage

// File: rtl/error_unit_if.sv
// Valid/ready stream bundle; the producer drives stb/dat, the consumer drives rdy.
interface error_unit_if #(parameter int W = 8) ();
    logic         stb;
    logic         rdy;
    logic [W-1:0] dat;

    modport master (output stb, output dat, input rdy);
    modport slave  (input stb, input dat, output rdy);
endinterface

// File: rtl/error_unit_stream_join.sv
// Two independent one-entry holding registers joined into a single "both full" flag.
module error_unit_stream_join
    import error_unit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_stb_i,
    input  act_t a_dat_i,
    output logic a_rdy_o,
    input  logic b_stb_i,
    input  act_t b_dat_i,
    output logic b_rdy_o,
    input  logic rel_i,    // consumer done: empty both entries
    output act_t a_dat_o,
    output act_t b_dat_o,
    output logic full_o
);

    logic a_full_q, b_full_q;
    act_t a_q, b_q;

    // Each side captures on its own handshake; release empties both together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (rel_i) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
        end else begin
            if (a_stb_i && !a_full_q) begin
                a_full_q <= 1'b1;
                a_q      <= a_dat_i;
            end
            if (b_stb_i && !b_full_q) begin
                b_full_q <= 1'b1;
                b_q      <= b_dat_i;
            end
        end
    end

    // Ready is a pure function of the full flops, never of the incoming strobe.
    assign a_rdy_o = !a_full_q;
    assign b_rdy_o = !b_full_q;
    assign a_dat_o = a_q;
    assign b_dat_o = b_q;
    assign full_o  = a_full_q && b_full_q;

endmodule

// File: rtl/error_unit.sv
// Error unit: joins activation and target, emits shifted/saturated signed error,
// and keeps sample count and saturating sum of absolute error.
module error_unit
    import error_unit_pkg::*;
#(
    parameter int SHIFT = 4,
    parameter int ACC_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               clr_i,
    error_unit_if.slave        act_if,
    error_unit_if.slave        tgt_if,
    error_unit_if.master       err_if,
    output logic [ACC_W-1:0]   acc_dat_o,
    output logic [15:0]        cnt_dat_o
);

    state_t           state_q;
    logic             err_stb_q;
    err_t             err_dat_q;
    logic [ACC_W-1:0] acc_q;
    logic [15:0]      cnt_q;

    act_t             act_v, tgt_v;
    logic             both_full;
    logic             done;
    diff_t            d;
    logic [7:0]       abs_d;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_d;
    err_t             err_d;

    // Holding registers stay loaded through CALC and SEND, so d is valid in both.
    error_unit_stream_join u_join (
        .clk     (clk),
        .rst     (rst),
        .a_stb_i (act_if.stb),
        .a_dat_i (act_if.dat),
        .a_rdy_o (act_if.rdy),
        .b_stb_i (tgt_if.stb),
        .b_dat_i (tgt_if.dat),
        .b_rdy_o (tgt_if.rdy),
        .rel_i   (done),
        .a_dat_o (act_v),
        .b_dat_o (tgt_v),
        .full_o  (both_full)
    );

    assign done    = (state_q == ST_SEND) && err_if.rdy;
    assign d       = $signed({1'b0, tgt_v}) - $signed({1'b0, act_v});
    assign abs_d   = d[8] ? 8'(-d) : d[7:0];
    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(abs_d);
    assign acc_d   = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign err_d   = en_i ? sat16(d, SHIFT) : '0;

    // Control FSM with registered outputs; clr overrides a same-cycle statistics update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_stb_q <= 1'b0;
            err_dat_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (both_full) state_q <= ST_CALC;
                ST_CALC: begin
                    err_dat_q <= err_d;
                    err_stb_q <= 1'b1;
                    state_q   <= ST_SEND;
                end
                ST_SEND: if (err_if.rdy) begin
                    err_stb_q <= 1'b0;
                    state_q   <= ST_IDLE;
                    cnt_q     <= cnt_q + 16'd1;
                    acc_q     <= acc_d;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (clr_i) begin
                acc_q <= '0;
                cnt_q <= '0;
            end
        end
    end

    assign err_if.stb = err_stb_q;
    assign err_if.dat = err_dat_q;
    assign acc_dat_o  = acc_q;
    assign cnt_dat_o  = cnt_q;

endmodule

// File: doc/error_unit.md
Name: error_unit

Overview:
- Training-side partner of the activation units: consumes the forward result stream from an activation (8-bit unsigned activation, 0xFF = 1.0) and a matching target stream.
- Produces the 16-bit signed error stream that feeds the activation's backward (err) port.
- Keeps running statistics (sample count, sum of absolute error) for convergence monitoring.

Parameters:
SHIFT, 4, left shift applied to the 9-bit signed difference before saturation to 16 bits (legal 0..8)
ACC_W, 24, width of the absolute-error accumulator

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
en  input  1  1 = error computed; 0 = err_dat forced to 0, handshakes still complete
clr  input  1  single-cycle pulse: zero acc_dat and cnt_dat
act_stb  input  1  activation valid
act_rdy  output  1  activation ready
act_dat  input  8  activation value, unsigned
tgt_stb  input  1  target valid
tgt_rdy  output  1  target ready
tgt_dat  input  8  target value, unsigned
err_stb  output  1  error valid
err_rdy  input  1  error ready
err_dat  output  16  error, signed
acc_dat  output  ACC_W  saturating sum of |tgt - act|
cnt_dat  output  16  completed-sample count, wraps modulo 2^16

Behaviour:
- Reset values: act_rdy = tgt_rdy = 1, err_stb = 0, err_dat = 0, acc_dat = 0, cnt_dat = 0, both holding registers empty, state IDLE.
- Transfer rule: a transfer occurs on a rising edge with stb & rdy both high.
  - Producers hold stb/dat until the transfer.
  - err_stb, once high, stays high with err_dat stable until err_rdy.
- Capture:
  - act and tgt have independent one-entry holding registers.
  - act_rdy = !act_full and tgt_rdy = !tgt_full, both registered; ready is not combinationally dependent on stb.
  - Either input may arrive first, or both in the same cycle.
- FSM states and transitions:
  - IDLE → CALC when both registers are full (evaluated on the cycle after the second capture).
  - CALC, one cycle:
    - d = tgt - act (9-bit signed); s = d << SHIFT saturated to [-32768, 32767].
    - err_dat <= en ? s : 0 (en sampled in CALC).
    - err_stb <= 1.
    - Go to SEND.
  - SEND, on err_rdy:
    - err_stb <= 0; both holding registers cleared (rdy high the next cycle).
    - cnt_dat += 1.
    - acc_dat += |d|, saturating at 2^ACC_W - 1.
    - Go to IDLE.
- Latency and throughput:
  - Last input captured at edge N → err_stb high after edge N+2.
  - Maximum throughput: one sample per 4 cycles.
- Inputs during CALC/SEND: rdy is low, so no capture.
- clr:
  - Zeroes acc_dat and cnt_dat on the next edge.
  - If coincident with a SEND completion, clr wins and that sample's contribution is discarded.
  - clr does not affect the data path.
- Reset mid-operation: all state returns to reset values immediately; an in-flight sample is lost and err_stb drops asynchronously.
- Boundary values:
  - d ranges over -255..255.
  - With SHIFT = 8, d = 255 gives 32767 (saturated) and d = -255 gives -32768 (saturated).
  - With SHIFT ≤ 7, no saturation occurs.

Decomposition:
- Shared package (machina_pkg, or existing equivalent):
  - act_t (logic [7:0]), err_t (logic signed [15:0]).
  - ERR_MAX / ERR_MIN constants.
  - Function sat16 (shift and saturate).
- Natural sub-module: stream_join, a two-input one-entry holding/join with independent ready.
- FSM, arithmetic and statistics stay in error_unit.

Test Plan:
- act = 0x00, tgt = 0xFF together, en = 1, SHIFT = 4, err_rdy = 1 → err_dat = 0x0FF0, err_stb high 2 cycles after capture, cnt_dat = 1, acc_dat = 255.
- act = 0xFF, tgt = 0x00, en = 1 → err_dat = 0xF010 (-4080).
- SHIFT = 8 (separate build), act = 0x00, tgt = 0xFF → err_dat = 0x7FFF; act = 0xFF, tgt = 0x00 → err_dat = 0x8000.
- act presented 5 cycles before tgt, err_rdy held low 10 cycles:
  - act_rdy low after act is captured; err_stb and err_dat stable throughout the stall.
  - Exactly one transfer when err_rdy rises.
- en = 0, act = 0x10, tgt = 0x80 → err_dat = 0, handshake completes, acc_dat += 112.
- clr pulsed in the same cycle as a SEND completion → acc_dat = 0, cnt_dat = 0.
- rst asserted during SEND → err_stb = 0 immediately, act_rdy = tgt_rdy = 1 after release, acc_dat = 0.
